// File: rtl/multicycle_control_unit.sv
// multicycle_control_unit
// Sequencing control unit for a small accumulator machine. Single-cycle ops
// (reg / ALU / branch) retire in DECODE; load/store stall the PC in MEM_WAIT
// until the data memory acknowledges or the wait times out. Opcode 15 halts.
// Optional build macro: CTRL_ILLEGAL_TRAP_EN -- when defined, a reserved
// opcode (16 .. 2^OPW-1) traps to HALT with Error set instead of acting as a NOP.
module multicycle_control_unit #(
  parameter int OPW         = 4,
  parameter int MEM_TIMEOUT = 16,
  parameter int CNTW        = 16
) (
  input  logic            Clk,
  input  logic            Reset_n,
  input  logic            Start,
  input  logic [OPW-1:0]  Opcode,
  input  logic            Identifier,
  input  logic            MemAck,
  output logic            RegWrite,
  output logic            AccWrite,
  output logic            MemRead,
  output logic            MemWrite,
  output logic            Branch,
  output logic            Lookup,
  output logic            ImmVal,
  output logic            PCEn,
  output logic            Busy,
  output logic            Done,
  output logic            Error,
  output logic [CNTW-1:0] InstrCount
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DECODE,
    S_MEM_WAIT,
    S_HALT
  } state_e;

  typedef enum logic [2:0] {
    C_LOAD,
    C_STORE,
    C_REG,
    C_ALU,
    C_BRANCH,
    C_HALT,
    C_RSV
  } op_class_e;

  // Timeout counter only has to reach MEM_TIMEOUT-1.
  localparam int TW = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [TW-1:0] TMO_LAST = (MEM_TIMEOUT > 0) ? TW'(MEM_TIMEOUT - 1) : '0;
  localparam logic          TMO_EN   = (MEM_TIMEOUT > 0);

  // Map an opcode onto its instruction class; anything above 15 is reserved.
  function automatic op_class_e classify(input logic [OPW-1:0] op);
    op_class_e c;
    c = C_HALT;
    if ((op >> 4) != '0)       c = C_RSV;
    else if (op[3:0] == 4'd0)  c = C_LOAD;
    else if (op[3:0] == 4'd1)  c = C_STORE;
    else if (op[3:0] == 4'd2)  c = C_REG;
    else if (op[3:0] <= 4'd11) c = C_ALU;
    else if (op[3:0] <= 4'd14) c = C_BRANCH;
    return c;
  endfunction

  state_e          r_state;
  state_e          w_next;
  logic [OPW:0]    r_ir;        // {opcode, identifier} of the pending memory op
  logic [TW-1:0]   r_tmo;
  logic [CNTW-1:0] r_count;
  logic            r_done;
  logic            r_error;

  op_class_e       w_class;
  op_class_e       w_ir_class;
  logic            w_ir_load;
  logic            w_tmo_hit;
  logic            w_retire;
  logic            w_latch;
  logic            w_set_done;
  logic            w_clr_done;
  logic            w_set_err;

  assign w_class    = classify(Opcode);
  assign w_ir_class = classify(r_ir[OPW:1]);
  assign w_ir_load  = (w_ir_class == C_LOAD);
  assign w_tmo_hit  = TMO_EN && (r_tmo == TMO_LAST);

  // State register.
  always_ff @(posedge Clk or negedge Reset_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!Reset_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  // Next-state, datapath strobes and bookkeeping requests.
  always_comb begin
    // NOTE: every output gets a default first, so no path can infer a latch.
    w_next     = r_state;
    RegWrite   = 1'b0;
    AccWrite   = 1'b0;
    MemRead    = 1'b0;
    MemWrite   = 1'b0;
    Branch     = 1'b0;
    Lookup     = 1'b0;
    ImmVal     = 1'b0;
    PCEn       = 1'b0;
    Busy       = 1'b0;
    w_retire   = 1'b0;
    w_latch    = 1'b0;
    w_set_done = 1'b0;
    w_clr_done = 1'b0;
    w_set_err  = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (Start) w_next = S_DECODE;
      end
      S_DECODE: begin
        Busy = 1'b1;
        unique case (w_class)
          C_LOAD: begin
            MemRead = 1'b1;
            ImmVal  = Identifier;
            w_latch = 1'b1;
            w_next  = S_MEM_WAIT;
          end
          C_STORE: begin
            MemWrite = 1'b1;
            w_latch  = 1'b1;
            w_next   = S_MEM_WAIT;
          end
          C_REG: begin
            RegWrite = 1'b1;
            PCEn     = 1'b1;
            w_retire = 1'b1;
          end
          C_ALU: begin
            AccWrite = 1'b1;
            ImmVal   = Identifier;
            PCEn     = 1'b1;
            w_retire = 1'b1;
          end
          C_BRANCH: begin
            Branch   = 1'b1;
            Lookup   = 1'b1;
            PCEn     = 1'b1;
            w_retire = 1'b1;
          end
          C_HALT: begin
            w_retire   = 1'b1;
            w_set_done = 1'b1;
            w_next     = S_HALT;
          end
          default: begin
`ifdef CTRL_ILLEGAL_TRAP_EN
            w_set_err = 1'b1;
            w_next    = S_HALT;
`else
            PCEn     = 1'b1;
            w_retire = 1'b1;
`endif
          end
        endcase
      end
      S_MEM_WAIT: begin
        Busy     = 1'b1;
        MemRead  = w_ir_load;
        MemWrite = !w_ir_load;
        ImmVal   = w_ir_load && r_ir[0];
        // An acknowledge in the timeout cycle still retires the instruction.
        if (MemAck) begin
          AccWrite = w_ir_load;
          PCEn     = 1'b1;
          w_retire = 1'b1;
          w_next   = S_DECODE;
        end else if (w_tmo_hit) begin
          w_set_err = 1'b1;
          w_next    = S_HALT;
        end
      end
      S_HALT: begin
        if (Start) begin
          w_clr_done = 1'b1;
          w_next     = S_DECODE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Instruction latch and memory-wait timeout counter.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_ir  <= '0;
      r_tmo <= '0;
    end else if (w_latch) begin
      r_ir  <= {Opcode, Identifier};
      r_tmo <= '0;
    end else if (r_state == S_MEM_WAIT && !MemAck && TMO_EN) begin
      r_tmo <= r_tmo + TW'(1);
    end
  end

  // Saturating retired-instruction counter.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n)                         r_count <= '0;
    else if (w_retire && r_count != '1)   r_count <= r_count + CNTW'(1);
  end

  // Done marks a clean halt; Error is sticky until reset.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_done  <= 1'b0;
      r_error <= 1'b0;
    end else begin
      if (w_set_done)                    r_done <= 1'b1;
      else if (w_clr_done || w_set_err)  r_done <= 1'b0;
      if (w_set_err)                     r_error <= 1'b1;
    end
  end

  assign Done       = r_done;
  assign Error      = r_error;
  assign InstrCount = r_count;

endmodule

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
- Multi-cycle successor to the single-cycle opcode decoder.
- Adds a sequencing FSM with start/halt, memory handshake stall, memory timeout, retired-instruction counter and parametrised opcode width.
- Sits between the instruction ROM/PC logic and the datapath (acc, reg file, data memory, branch lookup table).
- Single-cycle ops still complete in one cycle. Load/store stall the PC until the memory acknowledges.

Parameters:
- OPW, 4, opcode width; codes 0..15 are defined, codes 16..2^OPW-1 are reserved.
- MEM_TIMEOUT, 16, max MEM_WAIT cycles before error; 0 disables the timeout.
- CNTW, 16, width of the retired-instruction counter.

Ports:
- Clk  in  1  clock, rising edge
- Reset_n  in  1  asynchronous, active-low reset
- Start  in  1  begin/restart execution
- Opcode  in  OPW  current instruction opcode
- Identifier  in  1  reg(0)/imm(1) selector
- MemAck  in  1  data memory done with current request
- RegWrite, AccWrite, MemRead, MemWrite, Branch, Lookup, ImmVal  out  1 each  datapath strobes
- PCEn  out  1  advance PC this cycle
- Busy  out  1  FSM in DECODE or MEM_WAIT
- Done  out  1  halted by opcode 15
- Error  out  1  sticky: memory timeout or illegal-op trap
- InstrCount  out  CNTW  retired instructions, saturating

Behaviour:
- Reset (async, Reset_n=0): state IDLE, ir=0, timeout count=0, InstrCount=0, Done=0, Error=0. All outputs 0 immediately, in any state, including mid-MEM_WAIT.
- Opcode classes:
  - 0 load: AccWrite, MemRead, ImmVal=Identifier.
  - 1 store: MemWrite.
  - 2 reg: RegWrite.
  - 3..11 ALU: AccWrite, ImmVal=Identifier.
  - 12..14 branch: Branch, Lookup.
  - 15 halt.
  - 16+ reserved.
- Strobes are combinational from state plus (Opcode, Identifier) in DECODE, or plus latched ir in MEM_WAIT. They are 0 in IDLE and HALT.
- IDLE: Busy=0. Start=1 -> DECODE next edge.
- DECODE (Busy=1):
  - reg/ALU/branch: strobes for 1 cycle, PCEn=1, InstrCount+1, stay in DECODE.
  - load/store: MemRead or MemWrite=1, PCEn=0, AccWrite=0. Latch {Opcode, Identifier} into ir. Clear timeout count. -> MEM_WAIT.
  - halt: PCEn=0, no strobes, InstrCount+1, -> HALT.
  - reserved: NOP, PCEn=1, InstrCount+1 (see optional feature).
  - Start and MemAck are ignored in DECODE.
- MEM_WAIT (Busy=1):
  - MemRead/MemWrite and ImmVal held from ir; PCEn=0.
  - MemAck=1: load asserts AccWrite=1 that same cycle. PCEn=1, InstrCount+1, -> DECODE.
  - MemAck=0: count+1. If MEM_TIMEOUT>0 and count==MEM_TIMEOUT-1, then Error<=1 and -> HALT (instruction not retired).
  - MemAck and timeout in the same cycle: the ack wins.
- HALT:
  - Done=1 when entered via opcode 15; Done=0 when entered via error.
  - Busy=0, PCEn=0.
  - Start=1 -> DECODE, clears Done; Error stays set until reset.
- InstrCount saturates at 2^CNTW-1 and never wraps.
- Error and Done are registered (update on the edge that enters HALT).

Optional Feature:
- Macro: CTRL_ILLEGAL_TRAP_EN.
- Defined: a reserved opcode in DECODE gives PCEn=0, no strobes, Error<=1, -> HALT, not counted.
- Undefined: a reserved opcode executes as a NOP as described under Behaviour.
- With OPW=4 there are no reserved codes, so the macro has no effect.

Test Plan:
- Reset then Start, opcodes 3 (Identifier=1), 2, 12 -> AccWrite+ImmVal, then RegWrite, then Branch+Lookup, one cycle each; PCEn=1 each cycle; InstrCount=3.
- Opcode 0, MemAck after 3 cycles -> MemRead high for 4 cycles, PCEn=0 for 3 cycles; AccWrite=1 and PCEn=1 in the ack cycle; InstrCount+1.
- Opcode 1, MemAck never, MEM_TIMEOUT=4 -> MemWrite high 5 cycles (DECODE + 4 in MEM_WAIT), then HALT with Error=1, Done=0, InstrCount unchanged.
- Opcode 15 -> HALT, Done=1, Busy=0. Start -> DECODE, Done=0.
- Reset_n low during MEM_WAIT -> all outputs 0 asynchronously, state IDLE, InstrCount=0.
- OPW=5, opcode 20 -> without macro: NOP, PCEn=1, count+1. With CTRL_ILLEGAL_TRAP_EN: HALT, Error=1.
